// File: rtl/psmac_pkg.sv
// Shared constants for the precision-scalable MAC: sign-mode codes and FSM states.
package psmac_pkg;
  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_US = 2'b01;
  localparam logic [1:0] MODE_SU = 2'b10;
  localparam logic [1:0] MODE_SS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } psmac_state_e;
endpackage

// File: rtl/psmac_seq_digit_mul2.sv
// Combinational 2x2-bit digit multiply; each digit independently signed or unsigned.
module digit_mul2 (
  input  logic       a_signed,
  input  logic       b_signed,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] prod
);
  logic signed [2:0] ax, bx;
  logic signed [5:0] p;

  // A third bit carries the sign (or a zero) so one signed multiply covers all modes.
  // The result always fits in 4 bits: unsigned max 9, signed range -6..4.
  always_comb begin
    ax   = {a_signed & a[1], a};
    bx   = {b_signed & b[1], b};
    p    = 6'(ax * bx);
    prod = p[3:0];
  end
endmodule

// File: rtl/psmac_seq.sv
// Iterative precision-scalable MAC: one 2x2 digit product per cycle into a wrapping accumulator.
module psmac_seq
  import psmac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out
);
  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int SW = $clog2(2 * WIDTH);

  psmac_state_e     state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [1:0]       a_dig, b_dig;
  logic             a_sgn, b_sgn, last_i, last_j;
  logic [3:0]       prod;
  logic [ACC_W-1:0] prod_ext, addend;
  logic [SW-1:0]    sh_amt;

  always_comb begin
    last_i = (i_q == IW'(D - 1));
    last_j = (j_q == IW'(D - 1));
    a_dig  = 2'(a_q >> {i_q, 1'b0});
    b_dig  = 2'(b_q >> {j_q, 1'b0});
    // Only the most significant digit of a signed operand carries the sign weight.
    a_sgn  = sel_q[1] & last_i;
    b_sgn  = sel_q[0] & last_j;
  end

  digit_mul2 u_mul (
    .a_signed (a_sgn),
    .b_signed (b_sgn),
    .a        (a_dig),
    .b        (b_dig),
    .prod     (prod)
  );

  always_comb begin
    prod_ext = {{(ACC_W-4){(a_sgn | b_sgn) & prod[3]}}, prod};
    sh_amt   = SW'({i_q, 1'b0}) + SW'({j_q, 1'b0});
    addend   = prod_ext << sh_amt;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sel_d   = sel;
          acc_d   = acc_clr ? '0 : acc_q;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_q + addend;
        if (last_j) begin
          j_d = '0;
          if (last_i) state_d = ST_DONE;
          else        i_d     = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= MODE_UU;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign acc_out   = acc_q;
endmodule
